// File: rtl/nios_uart_tx_parity.sv
// Avalon-MM UART transmitter: 8N1/8E1/8O1 framing with a programmable bit divisor.
// Define NIOS_UART_TX_HOLD_EN to add a one-byte holding register for back-to-back frames.
module nios_uart_tx_parity #(
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd434,
  parameter logic [1:0]  DEFAULT_PARITY  = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        txd,
  output logic        tx_parity
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_DIVISOR = 2'd3;

  state_t      state_reg, state_next;

  // Software-visible registers
  logic [1:0]  ctrl_reg;
  logic [15:0] div_reg;
  logic        overrun_reg;
  logic [31:0] readdata_reg;

  // Byte waiting to launch; doubles as the holding register when that build option is on
  logic        pend_valid_reg;
  logic [7:0]  pend_data_reg;

  // Per-frame copies, frozen at launch so mid-frame register writes do not disturb the line
  logic [7:0]  frame_data_reg;
  logic [15:0] frame_div_reg;
  logic        frame_par_en_reg;
  logic        parity_reg;

  logic [2:0]  bit_cnt_reg;
  logic [15:0] baud_cnt_reg;

  logic        busy;
  logic        ready;
  logic        data_wr;
  logic        data_accept;
  logic        overrun_set;
  logic        overrun_clr;
  logic        bit_done;
  logic        launch;
  logic [15:0] div_wr_val;
  logic [8:0]  par_chain;
  logic        unused_wd;

  assign unused_wd = ^writedata[31:16];

  assign busy = (state_reg != ST_IDLE) || pend_valid_reg;

`ifdef NIOS_UART_TX_HOLD_EN
  assign ready = !pend_valid_reg;
`else
  assign ready = !busy;
`endif

  assign data_wr     = write && (address == ADDR_DATA);
  assign data_accept = data_wr && ready;
  assign overrun_set = data_wr && !ready;
  assign overrun_clr = write && (address == ADDR_STATUS) && writedata[2];
  assign div_wr_val  = (writedata[15:0] < 16'd2) ? 16'd2 : writedata[15:0];

  assign bit_done = (baud_cnt_reg == 16'd0);
  // A pending byte starts from IDLE immediately, or straight out of the final STOP cycle
  assign launch   = pend_valid_reg &&
                    ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && bit_done));

  // Parity of the byte about to launch, seeded with par_odd
  assign par_chain[0] = ctrl_reg[1];
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_par
      assign par_chain[gi+1] = par_chain[gi] ^ pend_data_reg[gi];
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (launch) state_next = ST_START;
      end
      ST_START: begin
        if (bit_done) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (bit_done && (bit_cnt_reg == 3'd7)) begin
          state_next = frame_par_en_reg ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (bit_done) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (launch)        state_next = ST_START;
        else if (bit_done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    txd = 1'b1;
    case (state_reg)
      ST_START:  txd = 1'b0;
      ST_DATA:   txd = frame_data_reg[bit_cnt_reg];
      ST_PARITY: txd = parity_reg;
      default:   txd = 1'b1;
    endcase
  end

  assign tx_parity = parity_reg;
  assign readdata  = readdata_reg;

  // Bit timing
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt_reg <= 16'd0;
      bit_cnt_reg  <= 3'd0;
    end else if (launch) begin
      baud_cnt_reg <= div_reg - 16'd1;
      bit_cnt_reg  <= 3'd0;
    end else if (state_reg != ST_IDLE) begin
      if (bit_done) begin
        baud_cnt_reg <= frame_div_reg - 16'd1;
        if (state_reg == ST_DATA) bit_cnt_reg <= bit_cnt_reg + 3'd1;
      end else begin
        baud_cnt_reg <= baud_cnt_reg - 16'd1;
      end
    end
  end

  // Frame latch
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_data_reg   <= 8'd0;
      frame_div_reg    <= DEFAULT_DIVISOR;
      frame_par_en_reg <= 1'b0;
      parity_reg       <= 1'b0;
    end else if (launch) begin
      frame_data_reg   <= pend_data_reg;
      frame_div_reg    <= div_reg;
      frame_par_en_reg <= ctrl_reg[0];
      parity_reg       <= par_chain[8];
    end
  end

  // Register file; an overrun in the same cycle as its W1C clear keeps the flag set
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_reg       <= DEFAULT_PARITY;
      div_reg        <= DEFAULT_DIVISOR;
      overrun_reg    <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_data_reg  <= 8'd0;
    end else begin
      if (write && (address == ADDR_CONTROL)) ctrl_reg <= writedata[1:0];
      if (write && (address == ADDR_DIVISOR)) div_reg  <= div_wr_val;

      if (overrun_set)      overrun_reg <= 1'b1;
      else if (overrun_clr) overrun_reg <= 1'b0;

      if (data_accept) begin
        pend_valid_reg <= 1'b1;
        pend_data_reg  <= writedata[7:0];
      end else if (launch) begin
        pend_valid_reg <= 1'b0;
      end
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_reg <= 32'd0;
    end else if (read) begin
      case (address)
        ADDR_STATUS:  readdata_reg <= {29'd0, overrun_reg, ready, busy};
        ADDR_CONTROL: readdata_reg <= {30'd0, ctrl_reg};
        ADDR_DIVISOR: readdata_reg <= {16'd0, div_reg};
        default:      readdata_reg <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_uart_tx_parity.sv
// Self-checking bench for nios_uart_tx_parity: a line monitor pops expected frames
// from a scoreboard queue filled as bytes are written.
module tb_nios_uart_tx_parity;

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       odd;
    int         div;
  } frame_t;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        txd;
  logic        tx_parity;

  int compared   = 0;
  int mismatched = 0;

  frame_t exp_q[$];
  logic [1:0]  cur_ctrl = 2'b01;
  int          cur_div  = 434;

  frame_t      mon_f;
  logic [10:0] mon_bits;
  logic        mon_par;
  int          mon_nbits;
  int          mon_idx;
  int          mon_cyc;
  logic        mon_bad;
  logic        mon_seen;
  logic        mon_active = 1'b0;

  nios_uart_tx_parity dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .read      (read),
    .readdata  (readdata),
    .txd       (txd),
    .tx_parity (tx_parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus tasks are entered on a falling edge and return on the next one
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    if (a == 2'd2) cur_ctrl = d[1:0];
    if (a == 2'd3) cur_div = (d[15:0] < 16'd2) ? 2 : int'(d[15:0]);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit expect_accept);
    frame_t f;
    if (expect_accept) begin
      f.data = d; f.par_en = cur_ctrl[0]; f.odd = cur_ctrl[1]; f.div = cur_div;
      exp_q.push_back(f);
    end
    bus_write(2'd0, {24'd0, d});
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !mon_active) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    compared++;
    if (!done) begin
      mismatched++;
      $display("FAIL wait_idle: %0d frames still expected, required 0 within 3000 cycles", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Line monitor: samples 2 time units after each rising edge
  task automatic run_monitor();
    forever begin
      @(posedge clk);
      #2;
      if (reset === 1'b1) begin
        mon_active = 1'b0;
      end else begin
        if (!mon_active && txd === 1'b0) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_frame: start bit seen at %0t, required idle line", $time);
          end else begin
            mon_f = exp_q.pop_front();
            mon_par = (^mon_f.data) ^ mon_f.odd;
            mon_bits = '1;
            mon_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) mon_bits[1+i] = mon_f.data[i];
            if (mon_f.par_en) begin
              mon_bits[9] = mon_par;
              mon_nbits = 11;
            end else begin
              mon_nbits = 10;
            end
            mon_idx = 0; mon_cyc = 0; mon_bad = 1'b0; mon_active = 1'b1;
          end
        end
        if (mon_active) begin
          if (txd !== mon_bits[mon_idx]) begin
            mon_bad = 1'b1;
            mon_seen = txd;
          end
          if (mon_cyc == mon_f.div - 1) begin
            compared++;
            if (mon_bad) begin
              mismatched++;
              $display("FAIL frame_bit: byte %02h bit %0d txd=%b required %b", mon_f.data, mon_idx,
                       mon_seen, mon_bits[mon_idx]);
            end
            mon_idx++; mon_cyc = 0; mon_bad = 1'b0;
            if (mon_idx == mon_nbits) begin
              compared++;
              if (tx_parity !== mon_par) begin
                mismatched++;
                $display("FAIL tx_parity: byte %02h tx_parity=%b required %b", mon_f.data, tx_parity, mon_par);
              end
              mon_active = 1'b0;
            end
          end else begin
            mon_cyc++;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] exp_vals [4];
    logic [1:0]  addrs [4];
    addrs = '{2'd1, 2'd2, 2'd3, 2'd0};
    exp_vals = '{32'h2, 32'h1, 32'd434, 32'h0};
    reset = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (txd !== 1'b1 || tx_parity !== 1'b0 || readdata !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: txd=%b tx_parity=%b readdata=%h required 1 0 0", txd, tx_parity, readdata);
    end
    reset = 1'b0;
    cur_ctrl = 2'b01; cur_div = 434;
    for (int i = 0; i < 4; i++) begin
      bus_read(addrs[i], rd);
      compared++;
      if (rd !== exp_vals[i] || txd !== 1'b1) begin
        mismatched++;
        $display("FAIL reset_read addr %0d: readdata=%h txd=%b required %h txd=1", addrs[i], rd, txd, exp_vals[i]);
      end
    end
  endtask

  task automatic test_frame(input logic [1:0] ctrl, input logic [7:0] data, input int div);
    logic [31:0] rd;
    int len;
    bus_write(2'd3, div);
    bus_write(2'd2, {30'd0, ctrl});
    send_byte(data, 1'b1);
    compared++;
    if (txd !== 1'b1) begin
      mismatched++;
      $display("FAIL frame_latency_pre: byte %02h txd=%b required 1", data, txd);
    end
    @(negedge clk);
    compared++;
    if (txd !== 1'b0) begin
      mismatched++;
      $display("FAIL frame_latency_start: byte %02h txd=%b required 0", data, txd);
    end
    len = (10 + int'(ctrl[0])) * div;
    repeat (len - 1) @(negedge clk);
    bus_read(2'd1, rd);
    compared++;
    if (rd[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL busy_last_cycle: cycle %0d busy=%b required 1", len, rd[0]);
    end
    bus_read(2'd1, rd);
    compared++;
    if (rd !== 32'h2) begin
      mismatched++;
      $display("FAIL busy_after_frame: status=%h required 00000002", rd);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    bus_write(2'd3, 32'd4);
    bus_write(2'd2, 32'd1);
    send_byte(8'h11, 1'b1);
    repeat (9) @(negedge clk);
`ifdef NIOS_UART_TX_HOLD_EN
    send_byte(8'h22, 1'b1);
    bus_read(2'd1, rd);
    compared++;
    if (rd !== 32'h1) begin
      mismatched++;
      $display("FAIL hold_status: status=%h required 00000001", rd);
    end
    repeat (33) @(negedge clk);
    compared++;
    if (txd !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_stop: cycle 44 txd=%b required 1", txd);
    end
    @(negedge clk);
    compared++;
    if (txd !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_no_gap: cycle 45 txd=%b required 0", txd);
    end
    wait_idle();
    bus_read(2'd1, rd);
    compared++;
    if (rd !== 32'h2) begin
      mismatched++;
      $display("FAIL b2b_idle_status: status=%h required 00000002", rd);
    end
`else
    send_byte(8'h22, 1'b0);
    bus_read(2'd1, rd);
    compared++;
    if (rd !== 32'h5) begin
      mismatched++;
      $display("FAIL overrun_set: status=%h required 00000005", rd);
    end
    wait_idle();
    bus_read(2'd1, rd);
    compared++;
    if (rd !== 32'h6) begin
      mismatched++;
      $display("FAIL overrun_sticky: status=%h required 00000006", rd);
    end
    bus_write(2'd1, 32'h4);
    bus_read(2'd1, rd);
    compared++;
    if (rd !== 32'h2) begin
      mismatched++;
      $display("FAIL overrun_clear: status=%h required 00000002", rd);
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    bus_write(2'd3, 32'd4);
    bus_write(2'd2, 32'd1);
    send_byte(8'h3C, 1'b1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if (txd !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_abort_txd: txd=%b required 1", txd);
    end
    reset = 1'b0;
    cur_ctrl = 2'b01; cur_div = 434;
    bus_read(2'd1, rd);
    compared++;
    if (rd !== 32'h2) begin
      mismatched++;
      $display("FAIL reset_abort_status: status=%h required 00000002", rd);
    end
    bus_read(2'd3, rd);
    compared++;
    if (rd !== 32'd434) begin
      mismatched++;
      $display("FAIL reset_abort_divisor: divisor=%0d required 434", rd);
    end
    test_frame(2'b01, 8'h3C, 4);
  endtask

  task automatic test_divisor();
    logic [31:0] rd;
    logic [31:0] wr_vals [3];
    logic [31:0] exp_vals [3];
    wr_vals = '{32'd1, 32'd0, 32'd3};
    exp_vals = '{32'd2, 32'd2, 32'd3};
    for (int i = 0; i < 3; i++) begin
      bus_write(2'd3, wr_vals[i]);
      bus_read(2'd3, rd);
      compared++;
      if (rd !== exp_vals[i]) begin
        mismatched++;
        $display("FAIL divisor_clamp: wrote %0d read %0d required %0d", wr_vals[i], rd, exp_vals[i]);
      end
    end
    bus_write(2'd3, 32'd4);
    send_byte(8'h5A, 1'b1);
    repeat (5) @(negedge clk);
    bus_write(2'd3, 32'd8);
    bus_read(2'd3, rd);
    compared++;
    if (rd !== 32'd8) begin
      mismatched++;
      $display("FAIL divisor_midframe_read: divisor=%0d required 8", rd);
    end
    wait_idle();
    send_byte(8'hC3, 1'b1);
    wait_idle();
  endtask

  initial begin
    reset = 1'b1; address = 2'd0; write = 1'b0; writedata = 32'd0; read = 1'b0;
    fork
      run_monitor();
    join_none
    test_reset();
    test_frame(2'b01, 8'hA5, 4);
    test_frame(2'b11, 8'hA5, 4);
    test_frame(2'b00, 8'hA5, 4);
    test_frame(2'b11, 8'h01, 3);
    test_back_to_back();
    test_reset_mid_frame();
    test_divisor();
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d frames left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
